cnn_maxpool2_stream: RTL and testbench

- Downstream neighbour of the second ReLU stage.
- Captures one 11x11 frame of non-negative 33-bit activations in a single cycle, then applies 2x2 stride-2 max pooling.
- Streams the resulting 5x5 map out one element per cycle over a valid/ready interface to the flatten/dense stage.
- Row 10 and column 10 of the input are discarded (floor pooling).

---
 rtl/cnn_pool_pkg.sv | 29 ++
 rtl/cnn_max4.sv | 40 ++++
 rtl/cnn_maxpool2_stream.sv | 122 ++++++++++++
 tb/tb_cnn_maxpool2_stream.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pool_pkg.sv
// rtl/cnn_pool_pkg.sv - shared constants, types and window addressing for the 2x2 max-pool stream
package cnn_pool_pkg;

  localparam int DATA_W  = 33;
  localparam int IN_DIM  = 11;
  localparam int OUT_DIM = IN_DIM / 2;
  localparam int FRAME_N = IN_DIM * IN_DIM;
  localparam int ADDR_W  = $clog2(FRAME_N);

  localparam logic [4:0] LAST_IDX = 5'(OUT_DIM * OUT_DIM - 1);

  typedef logic signed [DATA_W-1:0] act_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    STREAM = 2'd2
  } pool_state_t;

  // Bank address of the top-left element of output window k (row-major k = r*OUT_DIM + c)
  function automatic logic [ADDR_W-1:0] win_base(input logic [4:0] k);
    int r;
    int c;
    r = int'(k) / OUT_DIM;
    c = int'(k) % OUT_DIM;
    return ADDR_W'((2 * r) * IN_DIM + 2 * c);
  endfunction

endpackage

// File: rtl/cnn_max4.sv
// rtl/cnn_max4.sv - combinational signed max of four activations with lowest-position argmax
module cnn_max4
  import cnn_pool_pkg::*;
(
  input  act_t       a0,
  input  act_t       a1,
  input  act_t       a2,
  input  act_t       a3,
  output act_t       max_val,
  output logic [1:0] max_pos
);

  act_t       top_val;
  act_t       bot_val;
  logic       top_pos;
  logic       bot_pos;

  // Two-level tree; strict '>' keeps the lower position on every tie
  always_comb begin
    top_val = a0;
    top_pos = 1'b0;
    if (a1 > a0) begin
      top_val = a1;
      top_pos = 1'b1;
    end
    bot_val = a2;
    bot_pos = 1'b0;
    if (a3 > a2) begin
      bot_val = a3;
      bot_pos = 1'b1;
    end
    max_val = top_val;
    max_pos = {1'b0, top_pos};
    if (bot_val > top_val) begin
      max_val = bot_val;
      max_pos = {1'b1, bot_pos};
    end
  end

endmodule

// File: rtl/cnn_maxpool2_stream.sv
// rtl/cnn_maxpool2_stream.sv - 11x11 frame capture, 2x2 stride-2 max pool, 5x5 streamed output (POOL_ARGMAX_EN adds out_argmax)
module cnn_maxpool2_stream
  import cnn_pool_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] pool_in [0:FRAME_N-1],
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_data,
  output logic [4:0]               out_idx,
  output logic                     out_last
`ifdef POOL_ARGMAX_EN
  ,
  output logic [1:0]               out_argmax
`endif
);

  pool_state_t       state;
  act_t              bank [0:FRAME_N-1];
  logic [4:0]        sel_idx;
  logic [ADDR_W-1:0] base;
  act_t              win_max;
  logic              hs;
`ifdef POOL_ARGMAX_EN
  logic [1:0]        win_pos;
`else
  logic [1:0]        win_pos_unused;
`endif

  assign in_ready = (state == IDLE);
  assign hs       = out_valid & out_ready;

  // Window feeding the comparator: idx 0 during FILL, the next idx during STREAM so a handshake loads it directly
  always_comb begin
    sel_idx = out_idx;
    if (state == STREAM && out_idx != LAST_IDX) begin
      sel_idx = out_idx + 5'd1;
    end
    base = win_base(sel_idx);
  end

  cnn_max4 u_max4 (
    .a0      (bank[base]),
    .a1      (bank[base + ADDR_W'(1)]),
    .a2      (bank[base + ADDR_W'(IN_DIM)]),
    .a3      (bank[base + ADDR_W'(IN_DIM + 1)]),
    .max_val (win_max),
`ifdef POOL_ARGMAX_EN
    .max_pos (win_pos)
`else
    .max_pos (win_pos_unused)
`endif
  );

  // Frame bank: cleared on reset, loaded as a whole only on the accept edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FRAME_N; i++) begin
        bank[i] <= '0;
      end
    end else if (in_valid && in_ready) begin
      for (int i = 0; i < FRAME_N; i++) begin
        bank[i] <= pool_in[i];
      end
    end
  end

  // Control FSM and registered output stage
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
      out_last  <= 1'b0;
`ifdef POOL_ARGMAX_EN
      out_argmax <= 2'd0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            out_idx <= '0;
            state   <= FILL;
          end
        end
        FILL: begin
          out_data  <= win_max;
          out_valid <= 1'b1;
          out_last  <= (sel_idx == LAST_IDX);
`ifdef POOL_ARGMAX_EN
          out_argmax <= win_pos;
`endif
          state     <= STREAM;
        end
        STREAM: begin
          if (hs) begin
            if (out_idx == LAST_IDX) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              state     <= IDLE;
            end else begin
              out_idx  <= sel_idx;
              out_data <= win_max;
              out_last <= (sel_idx == LAST_IDX);
`ifdef POOL_ARGMAX_EN
              out_argmax <= win_pos;
`endif
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cnn_maxpool2_stream.sv
// tb/tb_cnn_maxpool2_stream.sv - directed and randomized self-checking bench for cnn_maxpool2_stream
module tb_cnn_maxpool2_stream;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic signed [32:0] pool_in [0:120];
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic signed [32:0] out_data;
  logic [4:0]        out_idx;
  logic              out_last;
`ifdef POOL_ARGMAX_EN
  logic [1:0]        out_argmax;
`endif

  logic signed [32:0] frm [0:120];
  logic signed [32:0] nxt [0:120];
  logic signed [32:0] got [0:24];
  logic [1:0]         got_pos [0:24];
  int total = 0;
  int bad = 0;
  int cyc0;

  always #5 clk = ~clk;

  cnn_maxpool2_stream dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .pool_in   (pool_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_last  (out_last)
`ifdef POOL_ARGMAX_EN
    ,
    .out_argmax(out_argmax)
`endif
  );

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: max over rows 2r..2r+1, cols 2c..2c+1; first position scanned wins ties
  task automatic ref_window(input int k, output logic signed [32:0] v, output logic [1:0] p);
    int r;
    int c;
    r = k / 5;
    c = k % 5;
    v = frm[(2 * r) * 11 + 2 * c];
    p = 2'd0;
    for (int dr = 0; dr < 2; dr++) begin
      for (int dc = 0; dc < 2; dc++) begin
        if (frm[(2 * r + dr) * 11 + 2 * c + dc] > v) begin
          v = frm[(2 * r + dr) * 11 + 2 * c + dc];
          p = 2'(dr * 2 + dc);
        end
      end
    end
  endtask

  task automatic rand_frame(input int mode);
    int v;
    for (int i = 0; i < 121; i++) begin
      if (mode == 0) begin
        frm[i] = 33'({$urandom(), $urandom()});
      end else begin
        v = int'($urandom_range(0, 6)) - 3;
        frm[i] = 33'(v);
      end
    end
  endtask

  task automatic ramp_frame();
    for (int i = 0; i < 121; i++) frm[i] = 33'(i);
  endtask

  task automatic run_frame(input int stall_idx, input int stall_len, input bit rnd, input bit keep);
    logic signed [32:0] ev [0:24];
    logic [1:0] ep [0:24];
    int k;
    int cyc;
    int stalled;
    for (int i = 0; i < 25; i++) ref_window(i, ev[i], ep[i]);
    for (int i = 0; i < 121; i++) pool_in[i] = frm[i];
    in_valid = 1'b1;
    out_ready = 1'b1;
    chk("accept_in_ready", in_ready, 1);
    @(negedge clk);
    chk("fill_in_ready", in_ready, 0);
    chk("fill_out_valid", out_valid, 0);
    if (keep) begin
      for (int i = 0; i < 121; i++) pool_in[i] = nxt[i];
    end else begin
      in_valid = 1'b0;
      for (int i = 0; i < 121; i++) pool_in[i] = 33'($urandom());
    end
    k = 0;
    cyc = 0;
    stalled = 0;
    while (k < 25 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (k == stall_idx && stalled < stall_len) begin
        out_ready = 1'b0;
        stalled++;
      end else if (rnd) begin
        out_ready = ($urandom_range(0, 3) != 0);
      end else begin
        out_ready = 1'b1;
      end
      chk("stream_out_valid", out_valid, 1);
      chk("stream_in_ready", in_ready, 0);
      chk("out_idx", out_idx, k);
      chk("out_data", out_data, ev[k]);
      chk("out_last", out_last, k == 24);
`ifdef POOL_ARGMAX_EN
      chk("out_argmax", out_argmax, ep[k]);
      got_pos[k] = out_argmax;
`endif
      got[k] = out_data;
      if (out_valid && out_ready) k++;
    end
    chk("handshakes", k, 25);
    @(negedge clk);
    chk("end_out_valid", out_valid, 0);
    chk("end_in_ready", in_ready, 1);
    chk("end_out_last", out_last, 0);
  endtask

  initial begin
    for (int i = 0; i < 121; i++) pool_in[i] = '0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_idx", out_idx, 0);
    chk("rst_out_last", out_last, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("idle_in_ready", in_ready, 1);
    chk("idle_out_valid", out_valid, 0);

    ramp_frame();
    run_frame(-1, 0, 1'b0, 1'b0);
    chk("ramp_out0", got[0], 12);
    chk("ramp_out4", got[4], 20);
    chk("ramp_out24", got[24], 108);

    ramp_frame();
    frm[120] = 33'sd1000;
    frm[65] = 33'sd999;
    run_frame(-1, 0, 1'b0, 1'b0);
    for (int k = 0; k < 25; k++) begin
      chk("edge_vs_ramp", got[k], ((2 * (k / 5) + 1) * 11 + 2 * (k % 5) + 1));
    end

    for (int i = 0; i < 121; i++) frm[i] = -33'sd5;
    frm[12] = -33'sd3;
    run_frame(-1, 0, 1'b0, 1'b0);
    chk("signed_out0", got[0], -3);
    chk("signed_out1", got[1], -5);
    chk("signed_out24", got[24], -5);
`ifdef POOL_ARGMAX_EN
    chk("signed_arg0", got_pos[0], 3);
    chk("signed_arg1", got_pos[1], 0);
`endif

    rand_frame(0);
    run_frame(7, 3, 1'b0, 1'b0);

    rand_frame(0);
    run_frame(-1, 0, 1'b1, 1'b0);
    rand_frame(1);
    run_frame(-1, 0, 1'b1, 1'b0);
    rand_frame(1);
    run_frame(12, 4, 1'b1, 1'b0);

    ramp_frame();
    for (int i = 0; i < 121; i++) pool_in[i] = frm[i];
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    cyc0 = 0;
    while (!(out_valid && out_idx == 5'd10) && cyc0 < 50) begin
      @(negedge clk);
      cyc0++;
    end
    chk("reach_idx10", out_idx, 10);
    #2 rst = 1'b0;
    #1;
    chk("async_out_valid", out_valid, 0);
    chk("async_out_data", out_data, 0);
    chk("async_in_ready", in_ready, 1);
    chk("async_out_idx", out_idx, 0);
    chk("async_out_last", out_last, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_out_valid", out_valid, 0);
    ramp_frame();
    run_frame(-1, 0, 1'b0, 1'b0);
    chk("post_rst_out0", got[0], 12);

    rand_frame(0);
    for (int i = 0; i < 121; i++) nxt[i] = 33'(i);
    run_frame(-1, 0, 1'b0, 1'b1);
    for (int i = 0; i < 121; i++) frm[i] = nxt[i];
    run_frame(-1, 0, 1'b0, 1'b0);
    chk("b2b_out0", got[0], 12);
    chk("b2b_out24", got[24], 108);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
